// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the direct-mapped data cache.
package dcache_pkg;

  // Tags are stored as the word address shifted right by the index width, so
  // one 30-bit field covers every legal SETS value.
  localparam int TAG_W = 30;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FETCH,
    FLUSH_CHK,
    FLUSH_WB,
    DONE
  } dcache_state_t;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } dcache_frame_t;

  // Frame index of a byte address (addr[idx_w+1:2]), zero-extended to 8 bits.
  function automatic logic [7:0] addr_idx(input logic [31:0] addr, input int idx_w);
    logic [31:0] m;
    logic [31:0] w;
    m = (32'd1 << idx_w) - 32'd1;
    w = (addr >> 2) & m;
    return w[7:0];
  endfunction

  // Tag of a byte address (addr[31:idx_w+2]), zero-extended.
  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr, input int idx_w);
    logic [31:0] w;
    w = addr >> (idx_w + 2);
    return w[TAG_W-1:0];
  endfunction

  // Rebuild the word-aligned byte address of a frame from its tag and index.
  function automatic logic [31:0] frame_addr(input logic [TAG_W-1:0] tag,
                                             input logic [7:0] idx, input int idx_w);
    logic [31:0] a;
    a = ({2'b00, tag} << idx_w) | {24'd0, idx};
    return a << 2;
  endfunction

endpackage

// File: rtl/dcache_frames.sv
// Frame storage: one combinational read port, one write port, and a
// separate per-frame dirty clear used when a write-back completes.
module dcache_frames
  import dcache_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] rd_idx,
  output dcache_frame_t    rd_frame,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  dcache_frame_t    wr_frame,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx
);

  dcache_frame_t frames [SETS];

  assign rd_frame = frames[rd_idx];

  // Frame array update; reset invalidates every frame.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) frames[i] <= '0;
    end else begin
      if (wr_en) frames[wr_idx] <= wr_frame;
      if (clr_en) frames[clr_idx].dirty <= 1'b0;
    end
  end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped, write-back, write-allocate data cache with one-word blocks
// and a halt-triggered flush of all dirty frames.
module dcache_dm
  import dcache_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  dcache_state_t    state, next_state;
  logic [IDX_W-1:0] fidx;
  logic [31:2]      miss_addr;

  logic [7:0]       req_idx8, miss_idx8;
  logic [IDX_W-1:0] req_idx, miss_idx, rd_idx, wr_idx, clr_idx;
  logic [TAG_W-1:0] req_tag, miss_tag;
  dcache_frame_t    rd, wr_frame;
  logic             wr_en, clr_en;
  logic             req, hit, victim_dirty, last;

  assign req_idx8  = addr_idx(dmemaddr, IDX_W);
  assign miss_idx8 = addr_idx({miss_addr, 2'b00}, IDX_W);
  assign req_idx   = req_idx8[IDX_W-1:0];
  assign miss_idx  = miss_idx8[IDX_W-1:0];
  assign req_tag   = addr_tag(dmemaddr, IDX_W);
  assign miss_tag  = addr_tag({miss_addr, 2'b00}, IDX_W);

  assign req          = dmemREN | dmemWEN;
  assign hit          = (state == IDLE) && !halt && req && rd.valid && (rd.tag == req_tag);
  assign victim_dirty = rd.valid && rd.dirty;
  assign last         = (fidx == IDX_W'(SETS - 1));

  // Read port follows the request in IDLE, the latched miss during a
  // miss, and the flush counter while flushing.
  always_comb begin
    rd_idx = fidx;
    case (state)
      IDLE:      rd_idx = req_idx;
      WB, FETCH: rd_idx = miss_idx;
      default:   rd_idx = fidx;
    endcase
  end

  dcache_frames #(.SETS(SETS), .IDX_W(IDX_W)) u_frames (
    .CLK      (CLK),
    .nRST     (nRST),
    .rd_idx   (rd_idx),
    .rd_frame (rd),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_frame (wr_frame),
    .clr_en   (clr_en),
    .clr_idx  (clr_idx)
  );

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; halt wins over a request in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (halt) next_state = FLUSH_CHK;
                 else if (req && !hit) next_state = victim_dirty ? WB : FETCH;
      WB:        if (!dwait) next_state = FETCH;
      FETCH:     if (!dwait) next_state = IDLE;
      FLUSH_CHK: if (victim_dirty) next_state = FLUSH_WB;
                 else if (last) next_state = DONE;
      FLUSH_WB:  if (!dwait) next_state = last ? DONE : FLUSH_CHK;
      default:   next_state = DONE;
    endcase
  end

  // Miss address latch and flush index; the index stops at the last frame.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      miss_addr <= '0;
      fidx      <= '0;
    end else begin
      if (state == IDLE && !halt && req && !hit) miss_addr <= dmemaddr[31:2];
      if (state == IDLE && halt) fidx <= '0;
      else if (state == FLUSH_CHK && !victim_dirty && !last) fidx <= fidx + 1'b1;
      else if (state == FLUSH_WB && !dwait && !last) fidx <= fidx + 1'b1;
    end
  end

  // Frame writes: write hits, fills, and dirty clears after write-backs.
  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = req_idx;
    wr_frame = '0;
    clr_en   = 1'b0;
    clr_idx  = fidx;
    case (state)
      IDLE: if (hit && dmemWEN) begin
        wr_en    = 1'b1;
        wr_frame = '{valid: 1'b1, dirty: 1'b1, tag: rd.tag, data: dmemstore};
      end
      FETCH: if (!dwait) begin
        wr_en    = 1'b1;
        wr_idx   = miss_idx;
        wr_frame = '{valid: 1'b1, dirty: 1'b0, tag: miss_tag, data: dload};
      end
      WB: if (!dwait) begin
        clr_en  = 1'b1;
        clr_idx = miss_idx;
      end
      FLUSH_WB: if (!dwait) clr_en = 1'b1;
      default: ;
    endcase
  end

  // Outputs: memory side is Moore on state; dhit/dmemload follow the request.
  always_comb begin
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    flushed  = (state == DONE);
    dhit     = hit;
    dmemload = hit ? rd.data : '0;
    case (state)
      FETCH: begin
        dREN  = 1'b1;
        daddr = {miss_addr, 2'b00};
      end
      WB, FLUSH_WB: begin
        dWEN   = 1'b1;
        daddr  = frame_addr(rd.tag, 8'(rd_idx), IDX_W);
        dstore = rd.data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_dm.sv
// Self-checking bench for dcache_dm: directed scenarios plus randomized
// traffic checked against a behavioural cache/memory model.
module tb_dcache_dm;

  localparam int SETS = 16;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        halt = 1'b0;
  logic        dmemREN = 1'b0, dmemWEN = 1'b0;
  logic [31:0] dmemaddr = '0, dmemstore = '0;
  logic        dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore;
  logic        dwait = 1'b1;
  logic [31:0] dload = '0;

  int pass_cnt = 0;
  int total = 0;

  dcache_dm #(.SETS(SETS)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload)
  );

  always #5 CLK = ~CLK;

  // ---------------- memory environment ----------------
  logic [31:0] pre [logic [31:0]];   // initial memory image set by tests
  logic [31:0] mem [logic [31:0]];   // values written by the cache
  logic [63:0] wr_log [$];           // {addr, data} of completed writes
  int          lat = 2;
  int          cnt = 0;
  logic        prev_act = 1'b0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // Memory responder: dwait high for 'lat' cycles of each transfer, then low.
  always @(posedge CLK) begin
    #2;
    if (!nRST) begin
      cnt = 0; dwait = 1'b1; prev_act = 1'b0;
    end else begin
      if (prev_act && !dwait) cnt = 0;
      prev_act = dREN | dWEN;
      if (dREN | dWEN) begin
        if (cnt < lat) begin
          dwait = 1'b1; cnt++;
        end else begin
          dwait = 1'b0;
          if (dWEN) begin
            mem[daddr] = dstore;
            wr_log.push_back({daddr, dstore});
          end else if (mem.exists(daddr)) dload = mem[daddr];
          else if (pre.exists(daddr)) dload = pre[daddr];
          else dload = init_val(daddr);
        end
      end else begin
        dwait = 1'b1; cnt = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic        mv [SETS];
  logic        md [SETS];
  logic [31:0] mt [SETS];
  logic [31:0] mdat [SETS];
  logic [31:0] rmem [logic [31:0]];
  logic [63:0] exp_wb [$];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (rmem.exists(a)) return rmem[a];
    if (pre.exists(a)) return pre[a];
    return init_val(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
  endtask

  task automatic model_access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rd, output logic miss);
    logic [31:0] w, t, va;
    int i;
    w = addr >> 2;
    i = int'(w % 32'(SETS));
    t = w / 32'(SETS);
    miss = !(mv[i] && mt[i] == t);
    if (miss) begin
      if (mv[i] && md[i]) begin
        va = (mt[i] * 32'(SETS) + 32'(i)) * 32'd4;
        rmem[va] = mdat[i];
        exp_wb.push_back({va, mdat[i]});
      end
      mv[i] = 1'b1; md[i] = 1'b0; mt[i] = t; mdat[i] = ref_rd(addr);
    end
    if (wen) begin mdat[i] = wdata; md[i] = 1'b1; end
    rd = mdat[i];
  endtask

  // ---------------- stimulus ----------------
  // Issue one request and hold it until dhit; reports latency and traffic order.
  task automatic access(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] got, output int cyc,
                        output logic saw_ren, output logic wen_first);
    logic saw_wen;
    @(posedge CLK); #1;
    dmemREN = ren; dmemWEN = wen; dmemaddr = addr; dmemstore = wdata;
    cyc = 0; saw_ren = 1'b0; saw_wen = 1'b0; wen_first = 1'b0;
    forever begin
      @(negedge CLK);
      if (dREN && !saw_ren) wen_first = saw_wen;
      if (dREN) saw_ren = 1'b1;
      if (dWEN) saw_wen = 1'b1;
      if (dREN && dWEN) begin
        total++;
        $display("FAIL excl_req: dREN=%0b dWEN=%0b, required not both 1", dREN, dWEN);
      end
      if (dREN && daddr !== {addr[31:2], 2'b00}) begin
        total++;
        $display("FAIL fetch_addr: daddr=%h, required %h", daddr, {addr[31:2], 2'b00});
      end
      if (dhit) break;
      cyc++;
      if (cyc > 300) begin
        total++;
        $display("FAIL access_timeout: addr=%h no dhit within 300 cycles", addr);
        break;
      end
    end
    got = dmemload;
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0;
  endtask

  task automatic do_reset();
    #2 nRST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) nRST = 1'b1;
    model_reset();
    exp_wb.delete();
    wr_log.delete();
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #1;
    total++;
    if ({dhit, flushed, dREN, dWEN} !== 4'b0 || daddr !== 32'h0 || dstore !== 32'h0 || dmemload !== 32'h0) begin
      $display("FAIL reset_outputs: hit=%0b fl=%0b ren=%0b wen=%0b daddr=%h dstore=%h load=%h, required all 0",
               dhit, flushed, dREN, dWEN, daddr, dstore, dmemload);
    end else pass_cnt++;
    repeat (2) @(posedge CLK);
    @(negedge CLK) nRST = 1'b1;
    model_reset();
  endtask

  task automatic test_cold_miss();
    logic [31:0] got, e; logic m, sr, wf; int cyc;
    pre[32'h40] = 32'hDEADBEEF;
    lat = 2;
    model_access(1'b0, 32'h40, 32'h0, e, m);
    access(1'b1, 1'b0, 32'h40, 32'h0, got, cyc, sr, wf);
    total++;
    if (got !== 32'hDEADBEEF) $display("FAIL cold_data: got %h, required DEADBEEF", got);
    else pass_cnt++;
    total++;
    if (!sr || cyc != lat + 2) $display("FAIL cold_latency: saw_ren=%0b wait=%0d, required 1 and %0d", sr, cyc, lat + 2);
    else pass_cnt++;
    access(1'b1, 1'b0, 32'h40, 32'h0, got, cyc, sr, wf);
    total++;
    if (got !== 32'hDEADBEEF || cyc != 0 || sr) $display("FAIL repeat_hit: got %h wait=%0d ren=%0b, required DEADBEEF 0 0", got, cyc, sr);
    else pass_cnt++;
  endtask

  task automatic test_write_hit();
    logic [31:0] got, e; logic m, sr, wf; int cyc;
    model_access(1'b1, 32'h40, 32'h12345678, e, m);
    access(1'b0, 1'b1, 32'h40, 32'h12345678, got, cyc, sr, wf);
    total++;
    if (cyc != 0 || wr_log.size() != 0) $display("FAIL write_hit: wait=%0d writes=%0d, required 0 0", cyc, wr_log.size());
    else pass_cnt++;
    model_access(1'b0, 32'h40, 32'h0, e, m);
    access(1'b1, 1'b0, 32'h40, 32'h0, got, cyc, sr, wf);
    total++;
    if (got !== e) $display("FAIL write_readback: got %h, required %h", got, e);
    else pass_cnt++;
  endtask

  task automatic test_dirty_evict();
    logic [31:0] got, e; logic m, sr, wf; int cyc;
    pre[32'h80] = 32'hCAFEF00D;
    model_access(1'b0, 32'h80, 32'h0, e, m);
    access(1'b1, 1'b0, 32'h80, 32'h0, got, cyc, sr, wf);
    total++;
    if (got !== 32'hCAFEF00D) $display("FAIL evict_data: got %h, required CAFEF00D", got);
    else pass_cnt++;
    total++;
    if (wr_log.size() != 1 || wr_log[0] !== {32'h40, 32'h12345678} || !wf)
      $display("FAIL evict_wb: writes=%0d first=%h wb_before_fetch=%0b, required 1 0000004012345678 1",
               wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 64'h0, wf);
    else pass_cnt++;
    wr_log.delete(); exp_wb.delete();
  endtask

  task automatic test_both_high();
    logic [31:0] got, e; logic m, sr, wf; int cyc;
    model_access(1'b1, 32'h80, 32'hA5A5A5A5, e, m);
    access(1'b1, 1'b1, 32'h80, 32'hA5A5A5A5, got, cyc, sr, wf);
    total++;
    if (cyc != 0) $display("FAIL both_hit: wait=%0d, required 0", cyc);
    else pass_cnt++;
    model_access(1'b0, 32'h80, 32'h0, e, m);
    access(1'b1, 1'b0, 32'h80, 32'h0, got, cyc, sr, wf);
    total++;
    if (got !== 32'hA5A5A5A5) $display("FAIL both_readback: got %h, required A5A5A5A5", got);
    else pass_cnt++;
    // Evicting the frame must write the new data back, proving it went dirty.
    model_access(1'b0, 32'h0, 32'h0, e, m);
    access(1'b1, 1'b0, 32'h0, 32'h0, got, cyc, sr, wf);
    total++;
    if (wr_log.size() != 1 || wr_log[0] !== {32'h80, 32'hA5A5A5A5})
      $display("FAIL both_dirty: writes=%0d first=%h, required 1 00000080A5A5A5A5",
               wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 64'h0);
    else pass_cnt++;
    wr_log.delete(); exp_wb.delete();
  endtask

  task automatic test_random();
    logic [31:0] got, e, addr, wd; logic m, sr, wf, ren, wen; int cyc, op;
    for (int n = 0; n < 300; n++) begin
      lat  = $urandom_range(0, 3);
      op   = $urandom_range(0, 2);
      ren  = (op != 1);
      wen  = (op != 0);
      addr = 32'($urandom_range(0, 63)) << 2;
      wd   = $urandom;
      model_access(wen, addr, wd, e, m);
      access(ren, wen, addr, wd, got, cyc, sr, wf);
      if (!wen) begin
        total++;
        if (got !== e) $display("FAIL rand_read: addr=%h got %h, required %h", addr, got, e);
        else pass_cnt++;
      end
      total++;
      if ((cyc != 0) != m) $display("FAIL rand_miss: addr=%h wait=%0d, required miss=%0b", addr, cyc, m);
      else pass_cnt++;
      total++;
      if (wr_log.size() != exp_wb.size() || (exp_wb.size() > 0 && wr_log[0] !== exp_wb[0]))
        $display("FAIL rand_wb: addr=%h writes=%0d first=%h, required %0d first=%h", addr, wr_log.size(),
                 (wr_log.size() > 0) ? wr_log[0] : 64'h0, exp_wb.size(), (exp_wb.size() > 0) ? exp_wb[0] : 64'h0);
      else pass_cnt++;
      wr_log.delete(); exp_wb.delete();
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] got, e; logic m, sr, wf; int cyc, k;
    do_reset();
    lat = 1;
    model_access(1'b0, 32'h40, 32'h0, e, m);
    access(1'b1, 1'b0, 32'h40, 32'h0, got, cyc, sr, wf);
    lat = 6;
    @(posedge CLK); #1;
    dmemREN = 1'b1; dmemaddr = 32'h440;
    k = 0;
    do begin @(negedge CLK); k++; end while (!dREN && k < 20);
    total++;
    if (!dREN) $display("FAIL midfetch_start: dREN=%0b, required 1", dREN);
    else pass_cnt++;
    #1 nRST = 1'b0;
    #1;
    total++;
    if (dREN !== 1'b0 || dWEN !== 1'b0 || flushed !== 1'b0)
      $display("FAIL midfetch_reset: dREN=%0b dWEN=%0b flushed=%0b, required 0 0 0", dREN, dWEN, flushed);
    else pass_cnt++;
    dmemREN = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) nRST = 1'b1;
    model_reset(); wr_log.delete(); exp_wb.delete();
    lat = 1;
    model_access(1'b0, 32'h40, 32'h0, e, m);
    access(1'b1, 1'b0, 32'h40, 32'h0, got, cyc, sr, wf);
    total++;
    if (!sr || cyc == 0 || got !== e) $display("FAIL after_reset_miss: ren=%0b wait=%0d got %h, required 1 >0 %h", sr, cyc, got, e);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    logic [31:0] got, e; logic m, sr, wf; int cyc, k;
    lat = 1;
    model_access(1'b1, 32'h40, 32'hF00D0040, e, m);
    access(1'b0, 1'b1, 32'h40, 32'hF00D0040, got, cyc, sr, wf);
    model_access(1'b1, 32'h54, 32'h55, e, m);
    access(1'b0, 1'b1, 32'h54, 32'h55, got, cyc, sr, wf);
    wr_log.delete(); exp_wb.delete();
    for (int i = 0; i < SETS; i++)
      if (mv[i] && md[i]) exp_wb.push_back({(mt[i] * 32'(SETS) + 32'(i)) * 32'd4, mdat[i]});
    @(posedge CLK); #1 halt = 1'b1;
    k = 0;
    do begin @(negedge CLK); k++; end while (!flushed && k < 500);
    total++;
    if (!flushed) $display("FAIL flush_done: flushed=%0b after %0d cycles, required 1", flushed, k);
    else pass_cnt++;
    total++;
    if (wr_log.size() != 2 || exp_wb.size() != 2)
      $display("FAIL flush_count: writes=%0d, required 2 (model %0d)", wr_log.size(), exp_wb.size());
    else pass_cnt++;
    for (int i = 0; i < 2 && i < wr_log.size() && i < exp_wb.size(); i++) begin
      total++;
      if (wr_log[i] !== exp_wb[i]) $display("FAIL flush_wb%0d: got %h, required %h", i, wr_log[i], exp_wb[i]);
      else pass_cnt++;
    end
    @(posedge CLK); #1;
    dmemREN = 1'b1; dmemaddr = 32'h40;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      total++;
      if (dhit !== 1'b0 || flushed !== 1'b1 || dREN !== 1'b0)
        $display("FAIL done_hold: dhit=%0b flushed=%0b dREN=%0b, required 0 1 0", dhit, flushed, dREN);
      else pass_cnt++;
    end
    @(posedge CLK); #1 halt = 1'b0; dmemREN = 1'b0;
    @(negedge CLK);
    total++;
    if (flushed !== 1'b1) $display("FAIL flushed_held: flushed=%0b, required 1", flushed);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_write_hit();
    test_dirty_evict();
    test_both_high();
    test_random();
    test_reset_mid_fetch();
    test_flush();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", pass_cnt, total);
    $fatal(1);
  end

endmodule
